// File: rtl/mmm_mod_add_ctrl_pkg.sv
// Shared definitions for the modular-add engine controller: state encoding
// and default sizing.
package mmm_mod_add_ctrl_pkg;

    // State encoding values (binary)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_WAIT  = ST_WAIT,
        S_DRAIN = ST_DRAIN,
        S_RESP  = ST_RESP
    } state_t;

    // Default operand / modulus / result width
    localparam int MMM_WIDTH_DEF   = 260;
    // Default number of WAIT cycles before a request is aborted (legal 2..65536)
    localparam int MMM_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/mmm_mod_add_ctrl_tmr.sv
// Wait counter with timeout compare. The counter saturates at TIMEOUT-1 so it
// never wraps; expired is a pure compare on the current count.
module mmm_mod_add_ctrl_tmr
    import mmm_mod_add_ctrl_pkg::*;
#(
    parameter int TIMEOUT = MMM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: clear wins, otherwise increment until the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register, asynchronously cleared by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmm_mod_add_ctrl.sv
// Request/response controller for an external modular-add engine. Accepts one
// request at a time, drives the engine until it flags done (or the wait times
// out), waits for the engine to return idle, then presents the response.
module mmm_mod_add_ctrl
    import mmm_mod_add_ctrl_pkg::*;
#(
    parameter int WIDTH   = MMM_WIDTH_DEF,
    parameter int TIMEOUT = MMM_TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    // request side
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_mode,
    input  logic [WIDTH-1:0] i_req_a,
    input  logic [WIDTH-1:0] i_req_b,
    input  logic [WIDTH-1:0] i_req_p,
    // response side
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_c,
    output logic             o_rsp_err,
    // engine side
    output logic             o_en,
    output logic             o_mode,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_p,
    input  logic [WIDTH-1:0] i_c,
    input  logic             i_flag
);

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
    logic             rsp_err_q, rsp_err_d;

    logic             tmr_clr;
    logic             tmr_inc;
    logic             tmr_expired;

    // Handshake outputs are decoded straight from the state register
    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);

    assign o_en      = en_q;
    assign o_mode    = mode_q;
    assign o_a       = a_q;
    assign o_b       = b_q;
    assign o_p       = p_q;
    assign o_rsp_c   = rsp_c_q;
    assign o_rsp_err = rsp_err_q;

    // The counter restarts on acceptance and only runs while waiting without a flag
    assign tmr_clr = (state_q == S_IDLE) && i_req_valid;
    assign tmr_inc = (state_q == S_WAIT) && !i_flag;

    mmm_mod_add_ctrl_tmr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk     (i_clk),
        .rstn    (i_rstn),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    // Next-state and datapath load decisions; everything holds by default
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        rsp_c_d   = rsp_c_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    a_d     = i_req_a;
                    b_d     = i_req_b;
                    p_d     = i_req_p;
                    mode_d  = i_req_mode;
                    en_d    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flag arriving on the timeout cycle still counts as success
                if (i_flag) begin
                    rsp_c_d   = i_c;
                    rsp_err_d = 1'b0;
                    en_d      = 1'b0;
                    state_d   = S_DRAIN;
                end else if (tmr_expired) begin
                    rsp_c_d   = '0;
                    rsp_err_d = 1'b1;
                    en_d      = 1'b0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Engine must drop its flag before we can issue again
                if (!i_flag) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared by reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            rsp_c_q   <= rsp_c_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule

// File: doc/mmm_mod_add_ctrl.md
MMM_MOD_ADD_CTRL -- requirements
Module: mmm_mod_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 260: operand, modulus and result width.
REQ-002 Parameter TIMEOUT, default 1024: maximum WAIT cycles before a request is aborted. Legal range 2..65536.
REQ-003 i_clk  input  1  clock; all state changes on the rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  input  1  upstream request valid.
REQ-006 o_req_ready  output  1  controller can accept a request.
REQ-007 i_req_mode  input  1  1 = reduced modular add (iterative); 0 = single-pass add.
REQ-008 i_req_a, i_req_b, i_req_p  input  WIDTH each  operands and modulus.
REQ-009 o_rsp_valid  output  1  result valid.
REQ-010 i_rsp_ready  input  1  downstream accepts the result.
REQ-011 o_rsp_c  output  WIDTH  result.
REQ-012 o_rsp_err  output  1  1 = timeout abort; o_rsp_c is then 0.
REQ-013 o_en, o_mode  output  1 each  drive the modular-add engine's i_en_addsub and i_mode.
REQ-014 o_a, o_b, o_p  output  WIDTH each  engine operands.
REQ-015 i_c  input  WIDTH  engine result.
REQ-016 i_flag  input  1  engine done flag.

Function
REQ-017 States: IDLE, WAIT, DRAIN, RESP, binary encoded. No other states are reachable.
REQ-018 o_req_ready is 1 only in IDLE, and is combinational from state.
REQ-019 In IDLE, when i_req_valid and o_req_ready are both 1:
  - register i_req_a/b/p into o_a/o_b/o_p;
  - register i_req_mode into o_mode;
  - set o_en to 1 and clear the wait counter;
  - go to WAIT.
REQ-020 o_a, o_b, o_p and o_mode SHALL hold stable from acceptance until the next acceptance.
REQ-021 In WAIT, when i_flag is 1:
  - capture i_c into o_rsp_c and clear o_rsp_err;
  - drive o_en to 0 on the next cycle;
  - go to DRAIN.
REQ-022 In WAIT with i_flag 0, the counter increments each cycle. When the counter equals TIMEOUT-1:
  - o_en goes to 0, o_rsp_c to 0 and o_rsp_err to 1;
  - go to DRAIN.
REQ-023 If i_flag and the timeout are true in the same cycle, i_flag wins: normal capture with err = 0.
REQ-024 In DRAIN, o_en stays 0 and the controller waits for i_flag = 0 (engine back at idle), then goes to RESP. This guarantees the engine is idle before the next issue.
REQ-025 In RESP, o_rsp_valid is 1. o_rsp_c and o_rsp_err hold stable until i_rsp_ready is 1; then go to IDLE.
REQ-026 o_rsp_valid is 1 only in RESP, and is combinational from state.
REQ-027 Latency, with an engine whose flag rises N cycles after o_en rises:
  - acceptance is at edge 0;
  - o_en rises after edge 0;
  - capture happens at edge N;
  - o_rsp_valid is asserted no earlier than edge N+2.
REQ-028 Throughput is one request in flight. A new request cannot be accepted in the cycle the response is consumed; ready returns the following cycle.
REQ-029 i_req_* values are sampled only on the accept edge. Changes to them at any other time SHALL have no effect.
REQ-030 The wait counter is $clog2(TIMEOUT) bits wide and never wraps. It is cleared on every acceptance.

Reset
REQ-031 While i_rstn = 0, the following are asynchronously forced and held: state = IDLE, o_en = 0, o_mode = 0, o_a/o_b/o_p = 0, o_rsp_c = 0, o_rsp_err = 0, counter = 0.
REQ-032 Reset asserted in any state aborts the in-flight request without producing a response. After release: o_req_ready = 1 and o_rsp_valid = 0.

Structure
REQ-033 A shared package SHALL hold:
  - the state encoding localparams (IDLE = 0, WAIT = 1, DRAIN = 2, RESP = 3);
  - the default WIDTH of 260;
  - the TIMEOUT default.
REQ-034 A single sub-module, mmm_mod_add_ctrl_tmr, SHALL implement the wait counter and timeout compare (ports: clk, rstn, clr, inc, expired).
REQ-035 The engine is not instantiated inside this block; the parent wires the engine ports.

Verification
REQ-036 All scenarios use a behavioural engine model unless stated otherwise.
REQ-037 Scenario 1: mode = 1, a = 5, b = 9, p = 11, model flag after 3 cycles with c = 3 -> o_rsp_c = 3, err = 0; o_en is high for exactly 3 cycles.
REQ-038 Scenario 2: mode = 0, a = 7, b = 8, model c = 15 after 1 cycle; i_rsp_ready held 0 for 5 cycles -> o_rsp_valid held and o_rsp_c = 15 stable throughout.
REQ-039 Scenario 3: TIMEOUT = 16, model never flags -> after 16 WAIT cycles o_en = 0; response has o_rsp_c = 0, o_rsp_err = 1.
REQ-040 Scenario 4: TIMEOUT = 16, model flag on the 16th WAIT cycle (the timeout cycle) -> err = 0 and i_c is captured.
REQ-041 Scenario 5: i_rstn pulsed low in WAIT -> o_en = 0 immediately, no response, next request completes normally.
REQ-042 Scenario 6: back-to-back requests with i_rsp_ready = 1 and i_req_valid = 1 held high -> each response is separated by an idle-accept cycle, no request is lost, and o_a changes only on the accept edge.
